// File: rtl/rotary_pkg.sv
// Shared constants for the rotary phase controller: value width and
// default timing/limit parameters.
package rotary_pkg;

    localparam int VALUE_W          = 16;
    localparam int POLL_DIV_DEF     = 2700;
    localparam int DEBOUNCE_CNT_DEF = 10;
    localparam int MAX_VALUE_DEF    = 338;

endpackage

// File: rtl/input_debounce.sv
// One raw asynchronous input: 2-flop synchronizer, poll-tick debouncer
// and single-clk rise/fall pulses issued on the tick the level flips.
module input_debounce
    import rotary_pkg::*;
#(
    parameter int   DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter logic RST_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             toggle;

    always_comb begin
        toggle  = 1'b0;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick_i) begin
            if (sync2_q != level_q) begin
                // Last differing sample of the run flips the level.
                if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                    toggle  = 1'b1;
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RST_LEVEL;
            sync2_q <= RST_LEVEL;
            level_q <= RST_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = toggle & ~level_q;
    assign fall_o  = toggle &  level_q;

endmodule

// File: rtl/rotary_phase_ctrl.sv
// Rotary encoder phase-offset controller: poll prescaler, three debounced
// inputs, detent decode and a bounded (saturating or wrapping) value register.
module rotary_phase_ctrl
    import rotary_pkg::*;
#(
    parameter int POLL_DIV     = POLL_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int MAX_VALUE    = MAX_VALUE_DEF,
    parameter int WRAP         = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rotary_a,
    input  logic               rotary_b,
    input  logic               slide_sw,
    output logic [VALUE_W-1:0] value,
    output logic               step,
    output logic               dir,
    output logic               cleared
);

    localparam int                 DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               tick;

    logic               a_level, a_rise, a_fall;
    logic               b_level, b_rise, b_fall;
    logic               sw_level, sw_rise, sw_fall;
    logic               unused_dbnc;

    logic [VALUE_W-1:0] value_q, value_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic               cleared_q, cleared_d;

    assign tick  = (div_q == DIV_W'(POLL_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    input_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .RST_LEVEL(1'b1)) u_dbnc_a (
        .clk(clk), .rst(rst), .raw_i(rotary_a), .tick_i(tick),
        .level_o(a_level), .rise_o(a_rise), .fall_o(a_fall)
    );

    input_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .RST_LEVEL(1'b1)) u_dbnc_b (
        .clk(clk), .rst(rst), .raw_i(rotary_b), .tick_i(tick),
        .level_o(b_level), .rise_o(b_rise), .fall_o(b_fall)
    );

    input_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .RST_LEVEL(1'b0)) u_dbnc_sw (
        .clk(clk), .rst(rst), .raw_i(slide_sw), .tick_i(tick),
        .level_o(sw_level), .rise_o(sw_rise), .fall_o(sw_fall)
    );

    // Only A falling, B level and switch rising drive the value logic.
    assign unused_dbnc = ^{a_level, a_rise, b_rise, b_fall, sw_level, sw_fall};

    always_comb begin
        value_d   = value_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        cleared_d = 1'b0;
        if (sw_rise) begin
            value_d   = '0;
            cleared_d = 1'b1;
        end else if (a_fall) begin
            if (b_level) begin
                if (value_q >= MAX_V) begin
                    value_d = (WRAP != 0) ? '0 : MAX_V;
                end else begin
                    value_d = value_q + VALUE_W'(1);
                end
            end else begin
                if (value_q == '0) begin
                    value_d = (WRAP != 0) ? MAX_V : '0;
                end else begin
                    value_d = value_q - VALUE_W'(1);
                end
            end
            // A saturated request leaves both step and dir untouched.
            if (value_d != value_q) begin
                step_d = 1'b1;
                dir_d  = b_level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            value_q   <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            cleared_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            value_q   <= value_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            cleared_q <= cleared_d;
        end
    end

    assign value   = value_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign cleared = cleared_q;

endmodule

// File: tb/tb_rotary_phase_ctrl.sv
// Bench for rotary_phase_ctrl: directed scenarios plus randomized inputs
// checked cycle by cycle against a tick-level behavioural model.
module tb_rotary_phase_ctrl;

    localparam int POLL_DIV = 4;
    localparam int DEB      = 3;
    localparam int MAXV     = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rot_a = 1'b1;
    logic        rot_b = 1'b1;
    logic        sw = 1'b0;
    logic [15:0] value0, value1;
    logic        step0, step1, dir0, dir1, clr0, clr1;

    int errors = 0;
    int checks = 0;
    int nstep0 = 0, nstep1 = 0, nclr0 = 0, nclr1 = 0;

    // Model state: index 0/1/2 = A/B/switch; value side index = WRAP setting.
    int m_div;
    bit m_raw[3], m_h1[3], m_h2[3], m_lvl[3];
    int m_cnt[3];
    int m_val[2];
    bit m_dir[2], m_step[2], m_clr[2];
    bit m_fall_a, m_rise_sw, m_bl;
    int m_nv;

    always #5 clk = ~clk;

    rotary_phase_ctrl #(.POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DEB), .MAX_VALUE(MAXV), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .rotary_a(rot_a), .rotary_b(rot_b), .slide_sw(sw),
        .value(value0), .step(step0), .dir(dir0), .cleared(clr0)
    );

    rotary_phase_ctrl #(.POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DEB), .MAX_VALUE(MAXV), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .rotary_a(rot_a), .rotary_b(rot_b), .slide_sw(sw),
        .value(value1), .step(step1), .dir(dir1), .cleared(clr1)
    );

    initial begin
        forever begin
            @(posedge clk);
            if (step0) nstep0++;
            if (step1) nstep1++;
            if (clr0)  nclr0++;
            if (clr1)  nclr1++;
        end
    end

    // Reference: every POLL_DIV clocks, compare the 2-clock-old input with the
    // accepted level; DEB consecutive disagreements accept the new level.
    initial begin
        forever begin
            @(posedge clk);
            m_raw[0] = rot_a;
            m_raw[1] = rot_b;
            m_raw[2] = sw;
            if (rst) begin
                m_div = 0;
                m_lvl = '{1'b1, 1'b1, 1'b0};
                m_h1  = m_lvl;
                m_h2  = m_lvl;
                m_cnt = '{0, 0, 0};
                for (int w = 0; w < 2; w++) begin
                    m_val[w] = 0; m_dir[w] = 1'b1; m_step[w] = 1'b0; m_clr[w] = 1'b0;
                end
            end else begin
                m_fall_a  = 1'b0;
                m_rise_sw = 1'b0;
                m_bl      = m_lvl[1];
                if (m_div == POLL_DIV - 1) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_h2[i] != m_lvl[i]) begin
                            m_cnt[i]++;
                            if (m_cnt[i] == DEB) begin
                                m_cnt[i] = 0;
                                m_lvl[i] = !m_lvl[i];
                                if (i == 0 && !m_lvl[0]) m_fall_a = 1'b1;
                                if (i == 2 && m_lvl[2])  m_rise_sw = 1'b1;
                            end
                        end else begin
                            m_cnt[i] = 0;
                        end
                    end
                end
                m_div = (m_div + 1) % POLL_DIV;
                m_h2  = m_h1;
                m_h1  = m_raw;
                for (int w = 0; w < 2; w++) begin
                    m_step[w] = 1'b0;
                    m_clr[w]  = 1'b0;
                    if (m_rise_sw) begin
                        m_val[w] = 0;
                        m_clr[w] = 1'b1;
                    end else if (m_fall_a) begin
                        if (m_bl) m_nv = (m_val[w] == MAXV) ? ((w == 1) ? 0 : MAXV) : m_val[w] + 1;
                        else      m_nv = (m_val[w] == 0) ? ((w == 1) ? MAXV : 0) : m_val[w] - 1;
                        if (m_nv != m_val[w]) begin
                            m_val[w]  = m_nv;
                            m_step[w] = 1'b1;
                            m_dir[w]  = m_bl;
                        end
                    end
                end
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n * POLL_DIV) @(negedge clk);
    endtask

    task automatic detent(input bit up);
        rot_b = up;
        ticks(5);
        rot_a = 1'b0;
        ticks(5);
        rot_a = 1'b1;
        ticks(5);
    endtask

    task automatic test_reset();
        rst = 1'b1; rot_a = 1'b1; rot_b = 1'b1; sw = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({value0, dir0, step0, clr0} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_wrap0 got value=%0d dir=%0b step=%0b cleared=%0b want 0/1/0/0", value0, dir0, step0, clr0);
        end
        checks++;
        if ({value1, dir1, step1, clr1} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_wrap1 got value=%0d dir=%0b step=%0b cleared=%0b want 0/1/0/0", value1, dir1, step1, clr1);
        end
        rst = 1'b0;
        ticks(4);
        checks++;
        if (value0 !== 16'd0 || nstep0 != 0 || nclr0 != 0) begin
            errors++;
            $display("FAIL idle_after_reset got value=%0d steps=%0d clears=%0d want 0/0/0", value0, nstep0, nclr0);
        end
    endtask

    task automatic test_increment();
        int s0 = nstep0;
        rot_b = 1'b1;
        rot_a = 1'b0;
        ticks(12);
        checks++;
        if (value0 !== 16'd1 || value1 !== 16'd1 || dir0 !== 1'b1 || (nstep0 - s0) != 1) begin
            errors++;
            $display("FAIL increment got value=%0d/%0d dir=%0b steps=%0d want 1/1 dir=1 steps=1", value0, value1, dir0, nstep0 - s0);
        end
        s0 = nstep0;
        rot_a = 1'b1;
        ticks(5);
        checks++;
        if (value0 !== 16'd1 || (nstep0 - s0) != 0) begin
            errors++;
            $display("FAIL a_rise_ignored got value=%0d steps=%0d want 1 steps=0", value0, nstep0 - s0);
        end
    endtask

    task automatic test_decrement();
        int s0;
        repeat (4) detent(1'b1);
        checks++;
        if (value0 !== 16'd5 || value1 !== 16'd5) begin
            errors++;
            $display("FAIL count_to_5 got value=%0d/%0d want 5/5", value0, value1);
        end
        s0 = nstep0;
        detent(1'b0);
        checks++;
        if (value0 !== 16'd4 || dir0 !== 1'b0 || (nstep0 - s0) != 1) begin
            errors++;
            $display("FAIL decrement got value=%0d dir=%0b steps=%0d want 4 dir=0 steps=1", value0, dir0, nstep0 - s0);
        end
        s0 = nstep0;
        rot_a = 1'b0;
        repeat (2 * POLL_DIV) @(negedge clk);
        rot_a = 1'b1;
        ticks(5);
        checks++;
        if (value0 !== 16'd4 || (nstep0 - s0) != 0) begin
            errors++;
            $display("FAIL glitch_rejected got value=%0d steps=%0d want 4 steps=0", value0, nstep0 - s0);
        end
    endtask

    task automatic test_saturate();
        int s0, s1;
        repeat (6) detent(1'b1);
        checks++;
        if (value0 !== 16'd10 || value1 !== 16'd10) begin
            errors++;
            $display("FAIL count_to_max got value=%0d/%0d want 10/10", value0, value1);
        end
        s0 = nstep0; s1 = nstep1;
        detent(1'b1);
        checks++;
        if (value0 !== 16'd10 || (nstep0 - s0) != 0 || dir0 !== 1'b1) begin
            errors++;
            $display("FAIL sat_high got value=%0d steps=%0d dir=%0b want 10 steps=0 dir=1", value0, nstep0 - s0, dir0);
        end
        checks++;
        if (value1 !== 16'd0 || (nstep1 - s1) != 1) begin
            errors++;
            $display("FAIL wrap_high got value=%0d steps=%0d want 0 steps=1", value1, nstep1 - s1);
        end
        detent(1'b0);
        checks++;
        if (value0 !== 16'd9 || value1 !== 16'd10 || dir1 !== 1'b0) begin
            errors++;
            $display("FAIL down_after_bound got value=%0d/%0d dir1=%0b want 9/10 dir1=0", value0, value1, dir1);
        end
    endtask

    task automatic test_clear();
        int s0, s1, c0, c1;
        detent(1'b0);
        detent(1'b0);
        checks++;
        if (value0 !== 16'd7) begin
            errors++;
            $display("FAIL count_to_7 got value=%0d want 7", value0);
        end
        s0 = nstep0; c0 = nclr0; c1 = nclr1;
        sw = 1'b1;
        ticks(20);
        checks++;
        if (value0 !== 16'd0 || value1 !== 16'd0 || (nclr0 - c0) != 1 || (nclr1 - c1) != 1 || (nstep0 - s0) != 0) begin
            errors++;
            $display("FAIL clear_held got value=%0d/%0d clears=%0d/%0d steps=%0d want 0/0 clears=1/1 steps=0",
                     value0, value1, nclr0 - c0, nclr1 - c1, nstep0 - s0);
        end
        sw = 1'b0;
        ticks(5);
        detent(1'b1);
        s0 = nstep0; s1 = nstep1; c0 = nclr0;
        rot_b = 1'b1;
        rot_a = 1'b0;
        sw = 1'b1;
        ticks(6);
        checks++;
        if (value0 !== 16'd0 || value1 !== 16'd0 || (nstep0 - s0) != 0 || (nstep1 - s1) != 0 || (nclr0 - c0) != 1) begin
            errors++;
            $display("FAIL clear_beats_detent got value=%0d/%0d steps=%0d/%0d clears=%0d want 0/0 steps=0/0 clears=1",
                     value0, value1, nstep0 - s0, nstep1 - s1, nclr0 - c0);
        end
        rot_a = 1'b1;
        sw = 1'b0;
        ticks(5);
        s0 = nstep0; s1 = nstep1;
        detent(1'b0);
        checks++;
        if (value0 !== 16'd0 || (nstep0 - s0) != 0 || dir0 !== 1'b1) begin
            errors++;
            $display("FAIL sat_low got value=%0d steps=%0d dir=%0b want 0 steps=0 dir=1", value0, nstep0 - s0, dir0);
        end
        checks++;
        if (value1 !== 16'd10 || (nstep1 - s1) != 1 || dir1 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_low got value=%0d steps=%0d dir=%0b want 10 steps=1 dir=0", value1, nstep1 - s1, dir1);
        end
    endtask

    task automatic test_reset_mid();
        int s0, s1;
        int budget = 0;
        detent(1'b1);
        rot_b = 1'b1;
        rot_a = 1'b0;
        while (m_cnt[0] != 2 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (m_cnt[0] != 2) begin
            errors++;
            $display("FAIL reset_mid_setup got model_count=%0d want 2 within 40 clks", m_cnt[0]);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = nstep0; s1 = nstep1;
        checks++;
        if (value0 !== 16'd0 || value1 !== 16'd0 || dir0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_value got value=%0d/%0d dir=%0b want 0/0 dir=1", value0, value1, dir0);
        end
        repeat (2 * POLL_DIV + 1) @(negedge clk);
        checks++;
        if ((nstep0 - s0) != 0 || value0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_no_early_step got steps=%0d value=%0d want 0/0", nstep0 - s0, value0);
        end
        ticks(3);
        checks++;
        if (value0 !== 16'd1 || value1 !== 16'd1 || (nstep0 - s0) != 1 || (nstep1 - s1) != 1) begin
            errors++;
            $display("FAIL reset_mid_redebounce got value=%0d/%0d steps=%0d/%0d want 1/1 steps=1/1",
                     value0, value1, nstep0 - s0, nstep1 - s1);
        end
        rot_a = 1'b1;
        ticks(5);
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 220; seg++) begin
            int hold;
            rot_a = 1'($urandom_range(0, 1));
            rot_b = 1'($urandom_range(0, 1));
            sw    = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            hold  = rst ? 1 : int'($urandom_range(1, 40));
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if (value0 !== 16'(m_val[0]) || step0 !== m_step[0] || dir0 !== m_dir[0] || clr0 !== m_clr[0]) begin
                    errors++;
                    $display("FAIL random_wrap0 t=%0t got v=%0d s=%0b d=%0b c=%0b want v=%0d s=%0b d=%0b c=%0b",
                             $time, value0, step0, dir0, clr0, m_val[0], m_step[0], m_dir[0], m_clr[0]);
                end
                checks++;
                if (value1 !== 16'(m_val[1]) || step1 !== m_step[1] || dir1 !== m_dir[1] || clr1 !== m_clr[1]) begin
                    errors++;
                    $display("FAIL random_wrap1 t=%0t got v=%0d s=%0b d=%0b c=%0b want v=%0d s=%0b d=%0b c=%0b",
                             $time, value1, step1, dir1, clr1, m_val[1], m_step[1], m_dir[1], m_clr[1]);
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_increment();
        test_decrement();
        test_saturate();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
